// File: rtl/clk_monitor.sv
// clk_monitor: measures period and high time of an asynchronous monitored
// clock in system-clock cycles, accumulates them over 2^WIN_LOG2 periods and
// flags loss of clock.
module clk_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_LOG2    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mon_in,
  output logic [CNT_W-1:0]          period_last,
  output logic [CNT_W-1:0]          period_min,
  output logic [CNT_W-1:0]          period_max,
  output logic [CNT_W+WIN_LOG2-1:0] period_sum,
  output logic [CNT_W+WIN_LOG2-1:0] high_sum,
  output logic                      meas_valid,
  output logic                      clk_lost
);

  localparam int unsigned SUM_W = CNT_W + WIN_LOG2;
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]    TMO_VAL = CNT_W'(TIMEOUT);
  localparam logic [WIN_LOG2-1:0] IDX_ONE = WIN_LOG2'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 s_d_q;
  logic                 s;
  logic                 rise;

  logic [CNT_W-1:0]     per_cnt_q, hi_cnt_q;
  logic [WIN_LOG2-1:0]  idx_q;
  logic [CNT_W-1:0]     min_acc_q, max_acc_q;
  logic [SUM_W-1:0]     psum_acc_q, hsum_acc_q;

  logic [CNT_W-1:0]     period_last_q, period_min_q, period_max_q;
  logic [SUM_W-1:0]     period_sum_q, high_sum_q;
  logic                 meas_valid_q, clk_lost_q;

  logic [CNT_W-1:0]     per_inc_d, hi_inc_d, min_d, max_d;
  logic [SUM_W-1:0]     psum_d, hsum_d;
  logic                 timeout_hit;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // Synchronizer chain for the asynchronous monitored clock plus edge-detect delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_in};
      s_d_q  <= s;
    end
  end

  // Saturating increments, accumulator updates including the current period, timeout test
  always_comb begin
    per_inc_d   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CNT_ONE;
    hi_inc_d    = hi_cnt_q;
    if (s && (hi_cnt_q != '1)) hi_inc_d = hi_cnt_q + CNT_ONE;
    min_d       = (per_cnt_q < min_acc_q) ? per_cnt_q : min_acc_q;
    max_d       = (per_cnt_q > max_acc_q) ? per_cnt_q : max_acc_q;
    psum_d      = psum_acc_q + SUM_W'(per_cnt_q);
    hsum_d      = hsum_acc_q + SUM_W'(hi_cnt_q);
    timeout_hit = (per_cnt_q >= TMO_VAL);
  end

  // Measurement FSM; per_cnt_q doubles as the since-last-rise timeout counter in ARM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      idx_q         <= '0;
      min_acc_q     <= '1;
      max_acc_q     <= '0;
      psum_acc_q    <= '0;
      hsum_acc_q    <= '0;
      period_last_q <= '0;
      period_min_q  <= '0;
      period_max_q  <= '0;
      period_sum_q  <= '0;
      high_sum_q    <= '0;
      meas_valid_q  <= 1'b0;
      clk_lost_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!en) begin
        state_q    <= IDLE;
        per_cnt_q  <= '0;
        hi_cnt_q   <= '0;
        idx_q      <= '0;
        clk_lost_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            idx_q      <= '0;
            clk_lost_q <= 1'b0;
            state_q    <= ARM;
          end
          ARM: begin
            if (rise) begin
              per_cnt_q  <= CNT_ONE;
              hi_cnt_q   <= CNT_ONE;
              idx_q      <= '0;
              min_acc_q  <= '1;
              max_acc_q  <= '0;
              psum_acc_q <= '0;
              hsum_acc_q <= '0;
              clk_lost_q <= 1'b0;
              state_q    <= MEASURE;
            end else if (timeout_hit) begin
              clk_lost_q <= 1'b1;
              per_cnt_q  <= '0;
            end else begin
              per_cnt_q  <= per_inc_d;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_last_q <= per_cnt_q;
              per_cnt_q     <= CNT_ONE;
              hi_cnt_q      <= CNT_ONE;
              idx_q         <= idx_q + IDX_ONE;
              if (idx_q == '1) begin
                period_min_q <= min_d;
                period_max_q <= max_d;
                period_sum_q <= psum_d;
                high_sum_q   <= hsum_d;
                meas_valid_q <= 1'b1;
                min_acc_q    <= '1;
                max_acc_q    <= '0;
                psum_acc_q   <= '0;
                hsum_acc_q   <= '0;
              end else begin
                min_acc_q    <= min_d;
                max_acc_q    <= max_d;
                psum_acc_q   <= psum_d;
                hsum_acc_q   <= hsum_d;
              end
            end else if (timeout_hit) begin
              clk_lost_q <= 1'b1;
              per_cnt_q  <= '0;
              hi_cnt_q   <= '0;
              idx_q      <= '0;
              state_q    <= ARM;
            end else begin
              per_cnt_q  <= per_inc_d;
              hi_cnt_q   <= hi_inc_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period_last = period_last_q;
  assign period_min  = period_min_q;
  assign period_max  = period_max_q;
  assign period_sum  = period_sum_q;
  assign high_sum    = high_sum_q;
  assign meas_valid  = meas_valid_q;
  assign clk_lost    = clk_lost_q;

endmodule
